// File: rtl/ili9341_byte_seq_pkg.sv
// Shared types for the ILI9341 byte sequencer: FSM states and the queued byte record.
package pkg_ili9341;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT,
        NEXT
    } seq_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } lcd_byte_t;

endpackage

// File: rtl/ili9341_byte_seq_fifo.sv
// Synchronous FIFO of {dc, byte} records. Full/empty are registered from the
// next-state level so they never depend combinationally on push/pop.
module lcd_byte_fifo
    import pkg_ili9341::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  lcd_byte_t              wr_entry,
    input  logic                   pop,
    output lcd_byte_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    lcd_byte_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [LW-1:0]     level_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop)
            level_nxt = level + LW'(1);
        else if (!do_push && do_pop)
            level_nxt = level - LW'(1);
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

    // Pointers, level and registered flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/ili9341_byte_seq.sv
// Feeds queued {dc, byte} entries to the SPI serializer one at a time and keeps
// chip-select asserted across back-to-back bytes.
module ili9341_byte_seq
    import pkg_ili9341::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_dc,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   spi_send,
    input  logic                   spi_done,
    output logic [7:0]             spi_data,
    output logic                   lcd_dc,
    output logic                   lcd_cs_n,
    output logic                   ovf,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int CW = $clog2(TIMEOUT);

    seq_state_t    state;
    seq_state_t    state_nxt;
    lcd_byte_t     head;
    lcd_byte_t     hold;
    logic          pop;
    logic          tmo;
    logic [CW-1:0] cnt;

    lcd_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .wr_entry ('{dc: wr_dc, data: wr_data}),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; pops happen only in IDLE and NEXT, and done beats the timeout.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = SEND;
            SEND:  state_nxt = WAIT;
            WAIT: begin
                if (spi_done)
                    state_nxt = NEXT;
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            NEXT: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cycles spent in WAIT; restarted while the send pulse is out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state == SEND)
            cnt <= '0;
        else if (state == WAIT)
            cnt <= cnt + CW'(1);
    end

    // Hold register keeps data and D/C stable from SETUP through WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hold <= '{dc: DC_CMD, data: 8'h00};
        else if (pop)
            hold <= head;
    end

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ovf         <= (wr_en && full) || (ovf && !err_clr);
            timeout_err <= tmo || (timeout_err && !err_clr);
        end
    end

    assign spi_send = (state == SEND);
    assign lcd_cs_n = (state == IDLE);
    assign busy     = (state != IDLE);
    assign spi_data = hold.data;
    assign lcd_dc   = hold.dc;

endmodule

// File: tb/tb_ili9341_byte_seq.sv
// Self-checking bench for ili9341_byte_seq: scoreboard on every send pulse,
// table-driven burst, and hand sequences for timeout, overflow and reset.
module tb_ili9341_byte_seq;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_dc = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, busy, spi_send, lcd_dc, lcd_cs_n, ovf, timeout_err;
    logic [LW-1:0] level;
    logic          spi_done = 1'b0;
    logic [7:0]    spi_data;
    logic          err_clr = 1'b0;

    ili9341_byte_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dc(wr_dc), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .busy(busy),
        .spi_send(spi_send), .spi_done(spi_done), .spi_data(spi_data),
        .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n), .ovf(ovf),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int send_count = 0;
    int cs_glitch = 0;
    bit cs_watch = 1'b0;
    bit done_en = 1'b1;
    int done_dly = 9;
    int resp_cnt = -1;
    logic [8:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic dc, input logic [7:0] d, input bit expect_sent);
        wr_en = 1'b1; wr_dc = dc; wr_data = d;
        if (expect_sent) sb.push_back({dc, d});
    endtask

    // Serializer model: answers each send pulse with a done pulse done_dly cycles later.
    always @(negedge clk) begin
        spi_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                spi_done = 1'b1;
                resp_cnt = -1;
            end
        end
        if (spi_send && done_en) resp_cnt = done_dly;
    end

    // Scoreboard: every send pulse must carry the oldest accepted entry.
    always @(negedge clk) begin
        if (rst && spi_send) begin
            send_count++;
            if (sb.size() == 0)
                chk("send_unexpected", 32'd1, 32'd0);
            else
                chk("send_byte", {23'd0, lcd_dc, spi_data}, {23'd0, sb.pop_front()});
        end
        if (cs_watch && lcd_cs_n) cs_glitch++;
    end

    task automatic wait_send(output int c);
        int n = 0;
        while (!spi_send && n < 300) begin tick(); n++; end
        if (!spi_send) chk("wait_send_expired", 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic wait_done(output int c);
        int n = 0;
        while (!spi_done && n < 300) begin tick(); n++; end
        if (!spi_done) chk("wait_done_expired", 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !empty) && n < 3000) begin tick(); n++; end
        chk("drain_idle", {31'd0, busy || !empty}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic       exp_dc;
        logic [7:0] exp_data;
    } vec_t;

    initial begin
        vec_t burst [3];
        int k, s, d, s_prev, sends0;

        burst[0] = '{dc: 1'b0, data: 8'h2C, exp_dc: 1'b0, exp_data: 8'h2C};
        burst[1] = '{dc: 1'b1, data: 8'hF8, exp_dc: 1'b1, exp_data: 8'hF8};
        burst[2] = '{dc: 1'b1, data: 8'h00, exp_dc: 1'b1, exp_data: 8'h00};

        // Reset state
        tick();
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_send", {31'd0, spi_send}, 32'd0);
        chk("rst_data", {24'd0, spi_data}, 32'd0);
        chk("rst_dc", {31'd0, lcd_dc}, 32'd0);
        chk("rst_cs", {31'd0, lcd_cs_n}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Single command: latency and CS release
        done_en = 1'b1; done_dly = 9;
        k = cyc;
        push(1'b0, 8'h2A, 1'b1);
        tick(); wr_en = 1'b0;
        chk("single_cs_c1", {31'd0, lcd_cs_n}, 32'd1);
        tick();
        chk("single_cs_c2", {31'd0, lcd_cs_n}, 32'd0);
        tick();
        chk("single_send_c3", {31'd0, spi_send}, 32'd1);
        chk("single_data", {24'd0, spi_data}, 32'h2A);
        chk("single_dc", {31'd0, lcd_dc}, 32'd0);
        tick();
        chk("single_send_1cyc", {31'd0, spi_send}, 32'd0);
        wait_done(d);
        chk("single_done_cyc", d - k, 32'd12);
        tick();
        chk("single_cs_d1", {31'd0, lcd_cs_n}, 32'd0);
        tick();
        chk("single_cs_d2", {31'd0, lcd_cs_n}, 32'd1);
        chk("single_busy_d2", {31'd0, busy}, 32'd0);

        // Burst from table: sends 3 cycles after each done, CS held low
        for (int i = 0; i < 3; i++) begin
            push(burst[i].dc, burst[i].data, 1'b1);
            tick();
        end
        wr_en = 1'b0;
        d = 0;
        for (int i = 0; i < 3; i++) begin
            wait_send(s);
            if (i == 0) begin cs_watch = 1'b1; cs_glitch = 0; end
            else chk("burst_gap", s - d, 32'd3);
            chk("burst_dc", {31'd0, lcd_dc}, {31'd0, burst[i].exp_dc});
            chk("burst_data", {24'd0, spi_data}, {24'd0, burst[i].exp_data});
            tick();
            wait_done(d);
        end
        cs_watch = 1'b0;
        chk("burst_cs_glitch", cs_glitch, 32'd0);
        wait_idle();

        // Overflow: one entry in flight, then DEPTH+2 pushes with done held off
        done_en = 1'b0;
        push(1'b1, 8'h10, 1'b1);
        tick(); wr_en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(1'b1, 8'h40 + 8'(i), i < DEPTH);
            tick();
        end
        wr_en = 1'b0;
        chk("ovf_level", {28'd0, level}, DEPTH);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        push(1'b1, 8'hEE, 1'b0);
        err_clr = 1'b1;
        tick(); wr_en = 1'b0; err_clr = 1'b0;
        chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
        chk("ovf_level_hold", {28'd0, level}, DEPTH);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        done_en = 1'b1; done_dly = 2;
        wait_idle();
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        chk("tmo_cleared", {31'd0, timeout_err}, 32'd0);

        // Timeout: flag appears after the last WAIT cycle, next entry still served
        done_en = 1'b0;
        push(1'b0, 8'h5A, 1'b1);
        tick(); wr_en = 1'b0;
        wait_send(s);
        while (cyc < s + TIMEOUT) tick();
        chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
        chk("tmo_cs_low", {31'd0, lcd_cs_n}, 32'd0);
        tick();
        chk("tmo_flag", {31'd0, timeout_err}, 32'd1);
        chk("tmo_cs_high", {31'd0, lcd_cs_n}, 32'd1);
        done_en = 1'b1; done_dly = 3;
        push(1'b1, 8'h5B, 1'b1);
        tick(); wr_en = 1'b0;
        wait_idle();
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;

        // Done on the final WAIT cycle beats the timeout
        done_dly = TIMEOUT;
        push(1'b1, 8'h77, 1'b1);
        tick(); wr_en = 1'b0;
        wait_send(s);
        while (cyc < s + TIMEOUT) tick();
        chk("edge_done_seen", {31'd0, spi_done}, 32'd1);
        tick();
        chk("edge_next_cs", {31'd0, lcd_cs_n}, 32'd0);
        chk("edge_no_tmo", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("edge_no_tmo2", {31'd0, timeout_err}, 32'd0);
        chk("edge_idle", {31'd0, busy}, 32'd0);

        // Reset mid-WAIT with three entries queued
        done_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'hA0 + 8'(i), 1'b1);
            tick();
        end
        wr_en = 1'b0;
        wait_send(s);
        repeat (2) tick();
        chk("rw_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rw_cs", {31'd0, lcd_cs_n}, 32'd1);
        chk("rw_empty", {31'd0, empty}, 32'd1);
        chk("rw_level", {28'd0, level}, 32'd0);
        chk("rw_send", {31'd0, spi_send}, 32'd0);
        sb.delete();
        tick(); rst = 1'b1;
        sends0 = send_count;
        repeat (20) tick();
        chk("rw_no_replay", send_count, sends0);

        // Simultaneous push and pop at level 1
        done_en = 1'b1; done_dly = 5;
        push(1'b0, 8'hB1, 1'b1);
        tick();
        push(1'b1, 8'hB2, 1'b1);
        tick(); wr_en = 1'b0;
        wait_done(d);
        chk("pp_level_before", {28'd0, level}, 32'd1);
        tick();
        chk("pp_in_next", {31'd0, lcd_cs_n}, 32'd0);
        push(1'b1, 8'hB3, 1'b1);
        tick(); wr_en = 1'b0;
        chk("pp_level_after", {28'd0, level}, 32'd1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
